// File: rtl/systolic_skew_feeder.sv
// Skews one column of A per cycle onto the systolic row inputs (row i delayed i extra cycles) and frames a K-column pass.
// Optional: define SKEW_FEED_UNDERFLOW_CNT_EN to add a 16-bit saturating underflow_cnt output.
module systolic_skew_feeder #(
  parameter int num_of_rows = 16,
  parameter int data_width  = 8,
  parameter int k_len       = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [data_width*num_of_rows-1:0]   in_col_tot,
  output logic [data_width*num_of_rows-1:0]   out_left_tot,
  output logic                                busy,
  output logic                                done,
  output logic                                underflow,
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
  output logic [15:0]                         underflow_cnt,
`endif
  output logic [1:0]                          dbg_state
);

  localparam int KW = (k_len > 1) ? $clog2(k_len) : 1;
  localparam int DW = (num_of_rows > 1) ? $clog2(num_of_rows) : 1;
  localparam logic [KW-1:0] COL_LAST     = KW'(k_len - 1);
  localparam logic [DW-1:0] DRAIN_LAST   = DW'(num_of_rows - 1);
  localparam logic [DW-1:0] DRAIN_PENULT = DW'(num_of_rows - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [KW-1:0]   col_cnt_q;
  logic [DW-1:0]   drain_cnt_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            done_q;
  logic            underflow_q;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
  logic [15:0]     uf_cnt_q;
`endif

  logic                                accept_d;
  logic [data_width*num_of_rows-1:0]   feed_d;

  // Handshake: a column moves on any edge where in_valid && in_ready; in_ready is
  // high for every STREAM cycle and the slot is consumed even when in_valid is low.
  always_comb begin
    accept_d = (state_q == S_STREAM) && in_valid;
    feed_d   = accept_d ? in_col_tot : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_cnt_q   <= '0;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
      uf_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= S_STREAM;
            col_cnt_q   <= '0;
            underflow_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
            uf_cnt_q    <= '0;
`endif
          end
        end
        S_STREAM: begin
          if (!in_valid) begin
            underflow_q <= 1'b1;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
            if (uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
`endif
          end
          if (col_cnt_q == COL_LAST) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= (num_of_rows == 1);
          end else begin
            col_cnt_q <= col_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // done is registered one cycle early so it lands on the last drain cycle.
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
            done_q      <= (drain_cnt_q == DRAIN_PENULT);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Row r is a free-running shift line of depth r+1; the oldest element sits in the top slice.
  for (genvar r = 0; r < num_of_rows; r++) begin : g_row
    logic [(r+1)*data_width-1:0] line_q;
    if (r == 0) begin : g_first
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) line_q <= '0;
        else      line_q <= feed_d[r*data_width +: data_width];
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) line_q <= '0;
        else      line_q <= {line_q[r*data_width-1:0], feed_d[r*data_width +: data_width]};
      end
    end
    assign out_left_tot[r*data_width +: data_width] = line_q[(r+1)*data_width-1 -: data_width];
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = underflow_q;
  assign dbg_state = state_q;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed passes plus random traffic against a pass-timing / history model.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int NW = N * W;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_col_tot = '0;
  logic [NW-1:0] out_left_tot;
  logic          busy;
  logic          done;
  logic          underflow;
  logic [1:0]    dbg_state;
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  systolic_skew_feeder #(
    .num_of_rows (N),
    .data_width  (W),
    .k_len       (K)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_col_tot   (in_col_tot),
    .out_left_tot (out_left_tot),
    .busy         (busy),
    .done         (done),
    .underflow    (underflow),
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_bad    = 0;
  int            cyc      = 0;
  int            s_start  = -100000;
  logic          uf_m     = 1'b0;
  int            ufcnt_m  = 0;
  logic [NW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic m_stream(input int c);
    return (c > s_start) && (c <= s_start + K);
  endfunction

  function automatic logic m_busy(input int c);
    return (c > s_start) && (c <= s_start + K + N);
  endfunction

  // Element accepted in cycle x shows on row i during cycle x+1+i.
  task automatic check_all();
    logic [NW-1:0] exp_out;
    logic [NW-1:0] h;
    int idx;
    exp_out = '0;
    for (int i = 0; i < N; i++) begin
      idx = cyc - 1 - i;
      if (idx >= 0 && idx < exp_q.size()) begin
        h = exp_q[idx];
        exp_out[i*W +: W] = h[i*W +: W];
      end
    end
    check_eq("out_left_tot", 64'(out_left_tot), 64'(exp_out));
    check_eq("in_ready", 64'(in_ready), 64'(m_stream(cyc)));
    check_eq("busy", 64'(busy), 64'(m_busy(cyc)));
    check_eq("done", 64'(done), 64'(cyc == s_start + K + N));
    check_eq("underflow", 64'(underflow), 64'(uf_m));
`ifdef SKEW_FEED_UNDERFLOW_CNT_EN
    check_eq("underflow_cnt", 64'(underflow_cnt), 64'(ufcnt_m));
`endif
  endtask

  // driver: one clock cycle; check outputs, then drive this cycle's inputs and advance the model
  task automatic cycle(input logic st, input logic vld, input logic [NW-1:0] col);
    logic strm;
    logic bsy;
    @(negedge clk);
    check_all();
    start      = st;
    in_valid   = vld;
    in_col_tot = col;
    strm = m_stream(cyc);
    bsy  = m_busy(cyc);
    if (strm && vld) exp_q.push_back(col);
    else             exp_q.push_back('0);
    if (strm && !vld) begin
      uf_m = 1'b1;
      if (ufcnt_m < 65535) ufcnt_m++;
    end
    if (st && !bsy) begin
      s_start = cyc;
      uf_m    = 1'b0;
      ufcnt_m = 0;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out"}, 64'(out_left_tot), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_ready"}, 64'(in_ready), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_uf"}, 64'(underflow), 64'(0));
  endtask

  // Asynchronous reset dropped between edges; outputs must clear before any clock edge.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    start = 1'b0; in_valid = 1'b0; in_col_tot = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
    s_start = -100000;
    uf_m    = 1'b0;
    ufcnt_m = 0;
  endtask

  task automatic clean_pass(input logic gap_second);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h04030201);
    cycle(1'b0, !gap_second, 32'h14131211);
    cycle(1'b0, 1'b1, 32'h24232221);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // reset in the middle of STREAM, then idle long enough to prove no done appears
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'hA4A3A2A1);
    mid_reset();
    repeat (10) cycle(1'b0, 1'b0, '0);

    // clean pass, then idle cycles
    clean_pass(1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // underflow on the 2nd STREAM slot; flag stays until next start
    clean_pass(1'b1);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // start pulses mid-STREAM and mid-DRAIN are ignored
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h34333231);
    cycle(1'b1, 1'b1, 32'h44434241);
    cycle(1'b0, 1'b1, 32'h54535251);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // back-to-back: underflow pass, then a clean pass started the cycle after done
    clean_pass(1'b1);
    clean_pass(1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, NW'($urandom));
    end
    repeat (N + K + 2) cycle(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the systolic array: accepts one column of matrix A per cycle (one element per array row) and drives the per-row left inputs with row i delayed by i extra cycles.
- Produces the diagonal wavefront the row chain needs and zero-fills before and after the stream.
- Frames one multiply pass of K columns: start, stream, drain, then a done pulse.

Parameters:
- num_of_rows, 16, number of array rows N (one left input per row)
- data_width, 8, element width; matches the row chain's data_width
- k_len, 16, columns of A streamed per pass (inner dimension K)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a pass; ignored unless IDLE
- in_valid  input  1  in_col_tot holds a valid column
- in_ready  output  1  feeder accepts a column this cycle
- in_col_tot  input  data_width*num_of_rows  column; row i element in bits [(i+1)*data_width-1 : i*data_width]
- out_left_tot  output  data_width*num_of_rows  skewed left inputs; same slicing per row
- busy  output  1  high in STREAM and DRAIN
- done  output  1  one-cycle pulse at end of drain
- underflow  output  1  sticky; set if in_valid is low in any STREAM cycle; cleared by start or reset

Behaviour:
- Reset (rst=0, asynchronous) clears all delay registers, FSM→IDLE, column counter→0, drain counter→0, in_ready=0, busy=0, done=0, underflow=0, out_left_tot=0.
- Per-row delay line: row i is a shift register of depth i+1.
  - Element accepted at edge t on row i appears on out_left_tot row i after edge t+i.
  - Row 0 is therefore registered output: visible the cycle after acceptance.
  - All lines shift every cycle, free-running; the array has no stall.
- Fill value: when no element is accepted in a cycle, zero enters every delay line. This covers IDLE, DRAIN, and STREAM cycles with in_valid=0.
- FSM IDLE:
  - in_ready=0.
  - start=1 → STREAM; column counter=0; underflow cleared.
- FSM STREAM:
  - in_ready=1.
  - Each cycle consumes one column slot, whether valid or not.
  - in_valid=1: in_col_tot is shifted in.
  - in_valid=0: zeros are shifted in and underflow is set. The slot is lost and is not retried.
  - Column counter increments every STREAM cycle.
  - When counter==k_len-1: → DRAIN, drain counter=0.
  - STREAM length is exactly k_len cycles.
- FSM DRAIN:
  - in_ready=0; zeros are shifted in.
  - The drain counter runs num_of_rows cycles, so the last element exits the row N-1 line.
  - At counter==num_of_rows-1: done=1 for that cycle, then → IDLE.
- start while busy is ignored: no restart, no effect on counters.
- Reset mid-pass aborts immediately: all state and delay lines are zeroed, and no done pulse is produced.
- Counter widths:
  - Column counter: clog2(k_len) bits, minimum 1.
  - Drain counter: clog2(num_of_rows) bits, minimum 1.
  - Counters never wrap within a pass.
- Pass length: busy is high for exactly k_len+num_of_rows cycles. done follows the last start-triggered STREAM cycle by num_of_rows cycles.
- Data passes unmodified; no arithmetic on elements.

Optional Feature:
- Macro: SKEW_FEED_UNDERFLOW_CNT_EN.
- Defined:
  - Adds output port underflow_cnt, 16 bits, saturating at 16'hFFFF.
  - Counts STREAM cycles with in_valid=0.
  - Cleared by reset and by an accepted start.
- Not defined:
  - Port and counter are absent.
  - Only the sticky underflow flag exists.

Test Plan (N=4, data_width=8, k_len=3):
- Reset mid-pass: drive rst=0 during STREAM → all outputs 0 at once (async); after release the FSM is IDLE and no done pulse appears.
- Clean pass: start, then columns {row3..row0} = {04,03,02,01}, {14,13,12,11}, {24,23,22,21} on consecutive cycles.
  - Row 0 shows 01,11,21 starting the cycle after the first acceptance.
  - Row 3 shows 04,14,24 starting 3 cycles later than row 0.
  - All other slots read 00.
  - busy high for 7 cycles; done pulses once; underflow=0.
- Underflow: same pass with in_valid=0 on the 2nd STREAM cycle.
  - Slot carries zeros on every row at its skewed time.
  - Third column is still accepted; done timing is unchanged.
  - underflow=1 until the next start; underflow_cnt=1 when the macro is defined.
- start during busy: pulse start mid-STREAM and mid-DRAIN → no change to counters, timing or done count.
- Back-to-back passes: start asserted the cycle after done → second pass is accepted, its output matches the clean-pass expectation, and underflow is cleared.
